// File: rtl/ysyx_22040386_core_seq.sv
// Multi-cycle control sequencer for the NPC core: FETCH -> DECODE -> (MEM) -> WB,
// with a bus-response watchdog, halt on ebreak, and cycle/instret counters.
module ysyx_22040386_core_seq #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_reg_write,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_done,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic        halt_err,
  output logic [2:0]  state,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_e          state_q, state_d;
  logic [31:0]     inst_q, inst_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic            halt_q, halt_d;
  logic            err_q, err_d;
  logic [63:0]     cycle_q, cycle_d;
  logic [63:0]     instret_q, instret_d;
  logic            retire;
  logic            wd_exp;

  // Expiry fires on the TIMEOUT-th waiting cycle; a response in that cycle takes priority.
  assign wd_exp = (TIMEOUT != 0) && (wait_q == WLAST);

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    wait_d  = wait_q;
    halt_d  = halt_q;
    err_d   = err_q;
    retire  = 1'b0;
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu_wen = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          state_d = S_DECODE;
        end else if (wd_exp) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_DECODE: begin
        if (inst_q == EBREAK) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          retire  = 1'b1;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = dec_mem_write;
        if (lsu_done) begin
          state_d = S_WB;
        end else if (wd_exp) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        rf_we   = dec_reg_write;
        retire  = 1'b1;
        state_d = S_FETCH;
        wait_d  = '0;
      end
      default: ;
    endcase
    cycle_d   = (state_q != S_HALT) ? cycle_q + 64'd1 : cycle_q;
    instret_d = retire ? instret_q + 64'd1 : instret_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      inst_q    <= '0;
      wait_q    <= '0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      wait_q    <= wait_d;
      halt_q    <= halt_d;
      err_q     <= err_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign inst      = inst_q;
  assign halt      = halt_q;
  assign halt_err  = err_q;
  assign state     = state_q;
  assign cycle_cnt = cycle_q;
  assign instret   = instret_q;

endmodule
